// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer, synchronous flush
// and saturating stall/bubble performance counters.
`timescale 1ns/1ps
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 9,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [DATA_W-1:0] dn_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state, state_next;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_next, skid_ctrl, skid_ctrl_next;
    logic [DATA_W-1:0] main_data, main_data_next, skid_data, skid_data_next;
    logic              xfer_in, xfer_out;

    assign dn_valid = (state != EMPTY);
    assign dn_data  = main_data;
    assign dn_ctrl  = dn_valid ? main_ctrl : '0;

    // The skid variant derives up_ready from state alone, keeping dn_ready off the upstream path.
    generate
        if (SKID != 0) begin : g_skid
            assign up_ready = !rst && !flush && (state != TWO);
        end else begin : g_single
            assign up_ready = !rst && !flush && (!dn_valid || dn_ready);
        end
    endgenerate

    assign xfer_in  = up_valid && up_ready;
    assign xfer_out = dn_valid && dn_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_next;
            main_ctrl <= main_ctrl_next;
            main_data <= main_data_next;
            skid_ctrl <= skid_ctrl_next;
            skid_data <= skid_data_next;
        end
    end

    always_comb begin
        state_next     = state;
        main_ctrl_next = main_ctrl;
        main_data_next = main_data;
        skid_ctrl_next = skid_ctrl;
        skid_data_next = skid_data;
        if (flush) begin
            state_next     = EMPTY;
            main_ctrl_next = '0;
            main_data_next = '0;
            skid_ctrl_next = '0;
            skid_data_next = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        main_ctrl_next = up_ctrl;
                        main_data_next = up_data;
                        state_next     = ONE;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_ctrl_next = up_ctrl;
                        main_data_next = up_data;
                    end else if (xfer_in) begin
                        if (SKID != 0) begin
                            skid_ctrl_next = up_ctrl;
                            skid_data_next = up_data;
                            state_next     = TWO;
                        end
                    end else if (xfer_out) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    // Skid entry is cleared once promoted so it never holds stale payload.
                    if (xfer_out) begin
                        main_ctrl_next = skid_ctrl;
                        main_data_next = skid_data;
                        skid_ctrl_next = '0;
                        skid_data_next = '0;
                        state_next     = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (dn_valid && !dn_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (!dn_valid && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
